// File: rtl/lowentropy_codebook_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------------
// lowentropy_codebook_encoder : per-code prefix accumulator and flush walker that
// queries an external combinational codebook. Optional macro: LE_BITCOUNT_EN.
// Revision 1.0
// ---------------------------------------------------------------------------------
module lowentropy_codebook_encoder #(
  parameter int NUM_CODES           = 16,
  parameter int MAX_SYMS            = 6,
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int ENCODE_DATALENGTH   = 21
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           sym_valid_i,
  output logic                           sym_ready_o,
  input  logic [$clog2(NUM_CODES)-1:0]   sym_code_i,
  input  logic [3:0]                     sym_data_i,
  input  logic                           flush_i,
  output logic                           flush_done_o,
  output logic [$clog2(NUM_CODES)-1:0]   lkp_code_o,
  output logic [5:0]                     lkp_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] lkp_data_o,
  input  logic                           lkp_match_i,
  input  logic [5:0]                     lkp_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   lkp_cw_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [$clog2(NUM_CODES)-1:0]   cw_code_o,
  output logic [5:0]                     cw_len_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic                           cw_flush_o,
  output logic                           ovf_err_o
`ifdef LE_BITCOUNT_EN
  ,
  input  logic                           bit_count_clr_i,
  output logic [31:0]                    bit_count_o
`endif
);

  localparam int CW = $clog2(NUM_CODES);
  localparam int PW = 4 * MAX_SYMS;
  localparam int NW = $clog2(MAX_SYMS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CODES - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPEND, S_EMIT, S_SCAN} state_t;

  state_t                       state_q, state_d;
  logic [PW-1:0]                prefix_q [NUM_CODES];
  logic [PW-1:0]                prefix_d [NUM_CODES];
  logic [NW-1:0]                cnt_q    [NUM_CODES];
  logic [NW-1:0]                cnt_d    [NUM_CODES];
  logic [CW-1:0]                code_q, code_d, idx_q, idx_d, cw_code_q, cw_code_d;
  logic [3:0]                   sym_q, sym_d;
  logic                         pend_q, pend_d, live_q, live_d, done_q, done_d;
  logic                         err_q, err_d, cw_flush_q, cw_flush_d;
  logic [5:0]                   cw_len_q, cw_len_d;
  logic [ENCODE_DATALENGTH-1:0] cw_data_q, cw_data_d;

  logic [CW-1:0] sel;
  logic [3:0]    nib;
  logic [PW+3:0] key;
  logic [5:0]    key_cnt;
  logic          lkp_en, sym_hs, cw_hs, walk_next;

  // APPEND looks up the latched symbol; SCAN terminates the walked prefix with 'hF
  always_comb begin
    sel     = (state_q == S_APPEND) ? code_q : idx_q;
    nib     = (state_q == S_APPEND) ? sym_q : 4'hF;
    key     = {prefix_q[sel], nib};
    key_cnt = 6'(cnt_q[sel]) + 6'd1;
    lkp_en  = (state_q == S_APPEND) || ((state_q == S_SCAN) && (cnt_q[idx_q] != '0));
  end

  assign lkp_code_o   = lkp_en ? sel : '0;
  assign lkp_cnt_o    = lkp_en ? key_cnt : '0;
  assign lkp_data_o   = lkp_en ? CODEBOOK_LENGTH_MAX'(key) : '0;
  assign sym_ready_o  = live_q && (state_q == S_IDLE) && !pend_q;
  assign sym_hs       = sym_valid_i && sym_ready_o;
  assign cw_valid_o   = (state_q == S_EMIT);
  assign cw_hs        = cw_valid_o && cw_ready_i;
  assign cw_code_o    = cw_code_q;
  assign cw_len_o     = cw_len_q;
  assign cw_data_o    = cw_data_q;
  assign cw_flush_o   = cw_flush_q;
  assign flush_done_o = done_q;
  assign ovf_err_o    = err_q;

  always_comb begin
    state_d    = state_q;
    prefix_d   = prefix_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    sym_d      = sym_q;
    idx_d      = idx_q;
    pend_d     = pend_q | flush_i;
    live_d     = 1'b1;
    done_d     = 1'b0;
    err_d      = err_q;
    cw_code_d  = cw_code_q;
    cw_len_d   = cw_len_q;
    cw_data_d  = cw_data_q;
    cw_flush_d = cw_flush_q;
    walk_next  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sym_hs) begin
          if (sym_data_i == 4'hF) begin
            err_d = 1'b1;
          end else begin
            code_d  = sym_code_i;
            sym_d   = sym_data_i;
            state_d = S_APPEND;
          end
        end else if (pend_q) begin
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_APPEND: begin
        state_d = S_IDLE;
        if (lkp_match_i) begin
          cw_code_d        = code_q;
          cw_len_d         = lkp_length_i;
          cw_data_d        = lkp_cw_i;
          cw_flush_d       = 1'b0;
          prefix_d[code_q] = '0;
          cnt_d[code_q]    = '0;
          state_d          = S_EMIT;
        end else if (key_cnt < 6'(MAX_SYMS)) begin
          prefix_d[code_q] = key[PW-1:0];
          cnt_d[code_q]    = NW'(key_cnt);
        end else begin
          err_d            = 1'b1;
          prefix_d[code_q] = '0;
          cnt_d[code_q]    = '0;
        end
      end
      S_EMIT: begin
        if (cw_ready_i) begin
          if (cw_flush_q) walk_next = 1'b1;
          else            state_d   = S_IDLE;
        end
      end
      S_SCAN: begin
        if (cnt_q[idx_q] == '0) begin
          walk_next = 1'b1;
        end else begin
          prefix_d[idx_q] = '0;
          cnt_d[idx_q]    = '0;
          if (lkp_match_i) begin
            cw_code_d  = idx_q;
            cw_len_d   = lkp_length_i;
            cw_data_d  = lkp_cw_i;
            cw_flush_d = 1'b1;
            state_d    = S_EMIT;
          end else begin
            err_d     = 1'b1;
            walk_next = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush requests arriving at the end of a walk are absorbed by this clear
    if (walk_next) begin
      if (idx_q == LAST_IDX) begin
        done_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + CW'(1);
        state_d = S_SCAN;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_CODES; i++) begin
        prefix_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      code_q     <= '0;
      sym_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      live_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cw_code_q  <= '0;
      cw_len_q   <= '0;
      cw_data_q  <= '0;
      cw_flush_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prefix_q   <= prefix_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      sym_q      <= sym_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      live_q     <= live_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cw_code_q  <= cw_code_d;
      cw_len_q   <= cw_len_d;
      cw_data_q  <= cw_data_d;
      cw_flush_q <= cw_flush_d;
    end
  end

`ifdef LE_BITCOUNT_EN
  logic [31:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (bit_count_clr_i)  bit_count_d = cw_hs ? 32'(cw_len_q) : '0;
    else if (cw_hs)       bit_count_d = bit_count_q + 32'(cw_len_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) bit_count_q <= '0;
    else          bit_count_q <= bit_count_d;
  end

  assign bit_count_o = bit_count_q;
`else
  // Emitted-bit accounting is compiled out.
`endif

endmodule
`default_nettype wire

// File: tb/tb_lowentropy_codebook_encoder.sv
`default_nettype none
// Directed bench for lowentropy_codebook_encoder with a small table-driven codebook.
module tb_lowentropy_codebook_encoder;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        sym_valid_i;
  logic        sym_ready_o;
  logic [3:0]  sym_code_i;
  logic [3:0]  sym_data_i;
  logic        flush_i;
  logic        flush_done_o;
  logic [3:0]  lkp_code_o;
  logic [5:0]  lkp_cnt_o;
  logic [63:0] lkp_data_o;
  logic        lkp_match_i;
  logic [5:0]  lkp_length_i;
  logic [20:0] lkp_cw_i;
  logic        cw_valid_o;
  logic        cw_ready_i;
  logic [3:0]  cw_code_o;
  logic [5:0]  cw_len_o;
  logic [20:0] cw_data_o;
  logic        cw_flush_o;
  logic        ovf_err_o;
`ifdef LE_BITCOUNT_EN
  logic        bit_count_clr_i = 1'b0;
  logic [31:0] bit_count_o;
`endif

  always #5 clk_i = ~clk_i;

  lowentropy_codebook_encoder dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .sym_valid_i  (sym_valid_i),
    .sym_ready_o  (sym_ready_o),
    .sym_code_i   (sym_code_i),
    .sym_data_i   (sym_data_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .lkp_code_o   (lkp_code_o),
    .lkp_cnt_o    (lkp_cnt_o),
    .lkp_data_o   (lkp_data_o),
    .lkp_match_i  (lkp_match_i),
    .lkp_length_i (lkp_length_i),
    .lkp_cw_i     (lkp_cw_i),
    .cw_valid_o   (cw_valid_o),
    .cw_ready_i   (cw_ready_i),
    .cw_code_o    (cw_code_o),
    .cw_len_o     (cw_len_o),
    .cw_data_o    (cw_data_o),
    .cw_flush_o   (cw_flush_o),
    .ovf_err_o    (ovf_err_o)
`ifdef LE_BITCOUNT_EN
    ,
    .bit_count_clr_i (bit_count_clr_i),
    .bit_count_o     (bit_count_o)
`endif
  );

  // Codebook: code, key length, key -> codeword length, codeword
  always_comb begin
    lkp_match_i  = 1'b0;
    lkp_length_i = '0;
    lkp_cw_i     = '0;
    if (lkp_code_o == 4'd7 && lkp_cnt_o == 6'd1 && lkp_data_o == 64'h9) begin
      lkp_match_i = 1'b1; lkp_length_i = 6'd4;  lkp_cw_i = 21'hA;
    end else if (lkp_code_o == 4'd5 && lkp_cnt_o == 6'd3 && lkp_data_o == 64'h20F) begin
      lkp_match_i = 1'b1; lkp_length_i = 6'd10; lkp_cw_i = 21'b1111100110;
    end else if (lkp_code_o == 4'd3 && lkp_cnt_o == 6'd2 && lkp_data_o == 64'h21) begin
      lkp_match_i = 1'b1; lkp_length_i = 6'd7;  lkp_cw_i = 21'h55;
    end else if (lkp_code_o == 4'd0 && lkp_cnt_o == 6'd1 && lkp_data_o == 64'h7) begin
      lkp_match_i = 1'b1; lkp_length_i = 6'd3;  lkp_cw_i = 21'h5;
    end else if (lkp_code_o == 4'd2 && lkp_cnt_o == 6'd2 && lkp_data_o == 64'hBF) begin
      lkp_match_i = 1'b1; lkp_length_i = 6'd5;  lkp_cw_i = 21'h1B;
    end
  end

  int          n_pass   = 0;
  int          n_checks = 0;
  int          cw_seen  = 0;
  logic [3:0]  last_code;
  logic [5:0]  last_len;
  logic [20:0] last_data;
  logic        last_flush;

  always @(posedge clk_i) begin
    if (rst_n_i && cw_valid_o && cw_ready_i) begin
      cw_seen    <= cw_seen + 1;
      last_code  <= cw_code_o;
      last_len   <= cw_len_o;
      last_data  <= cw_data_o;
      last_flush <= cw_flush_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
  endtask

  task automatic send_sym(input logic [3:0] c, input logic [3:0] d);
    int n;
    n = 0;
    sym_valid_i = 1'b1;
    sym_code_i  = c;
    sym_data_i  = d;
    while (!sym_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("sym_accept", 64'(sym_ready_o), 64'd1);
    @(negedge clk_i);
    sym_valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!flush_done_o && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    check("flush_done_seen", 64'(flush_done_o), 64'd1);
  endtask

  initial begin
    int cyc;
    int seen0;
    rst_n_i     = 1'b0;
    sym_valid_i = 1'b0;
    sym_code_i  = '0;
    sym_data_i  = '0;
    flush_i     = 1'b0;
    cw_ready_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready",    64'(sym_ready_o),  64'd0);
    check("rst_valid",    64'(cw_valid_o),   64'd0);
    check("rst_done",     64'(flush_done_o), 64'd0);
    check("rst_err",      64'(ovf_err_o),    64'd0);
    check("rst_lkp_cnt",  64'(lkp_cnt_o),    64'd0);
    check("rst_lkp_data", lkp_data_o,        64'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", 64'(sym_ready_o), 64'd1);

    // Leave code 1 non-empty, then reach EMIT on code 7 and reset mid-EMIT
    send_sym(4'd1, 4'h3);
    send_sym(4'd7, 4'h9);
    check("append_lkp_code", 64'(lkp_code_o), 64'd7);
    check("append_lkp_cnt",  64'(lkp_cnt_o),  64'd1);
    check("append_lkp_data", lkp_data_o,      64'h9);
    check("append_no_valid", 64'(cw_valid_o), 64'd0);
    @(negedge clk_i);
    check("emit_valid", 64'(cw_valid_o), 64'd1);
    check("emit_word",  64'({cw_code_o, cw_len_o, cw_data_o, cw_flush_o}),
                        64'({4'd7, 6'd4, 21'hA, 1'b0}));
    #2 rst_n_i = 1'b0;
    #1;
    check("async_rst_valid", 64'(cw_valid_o),  64'd0);
    check("async_rst_ready", 64'(sym_ready_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("release_ready", 64'(sym_ready_o), 64'd1);
    check("release_valid", 64'(cw_valid_o),  64'd0);
    cw_ready_i = 1'b1;
    seen0 = cw_seen;
    pulse_flush();
    wait_done(cyc);
    check("empty_walk_cycles_in_range", 64'(cyc >= 16 && cyc <= 20), 64'd1);
    check("empty_walk_no_cw", 64'(cw_seen - seen0), 64'd0);
    check("empty_walk_no_err", 64'(ovf_err_o), 64'd0);
    @(negedge clk_i);
    check("done_one_cycle", 64'(flush_done_o), 64'd0);

    // Code 5: two unmatched symbols, flushed as key 'h20F
    send_sym(4'd5, 4'h2);
    send_sym(4'd5, 4'h0);
    @(negedge clk_i);
    check("code5_no_err", 64'(ovf_err_o), 64'd0);
    seen0 = cw_seen;
    pulse_flush();
    wait_done(cyc);
    check("flush5_count", 64'(cw_seen - seen0), 64'd1);
    check("flush5_word", 64'({last_code, last_len, last_data, last_flush}),
                         64'({4'd5, 6'd10, 21'b1111100110, 1'b1}));
    check("flush5_no_err", 64'(ovf_err_o), 64'd0);

    // Code 5 now empty: skipped, not looked up as 'hF
    @(negedge clk_i);
    seen0 = cw_seen;
    pulse_flush();
    wait_done(cyc);
    check("empty5_no_cw",  64'(cw_seen - seen0), 64'd0);
    check("empty5_no_err", 64'(ovf_err_o), 64'd0);

    // Code 3 backpressure
    @(negedge clk_i);
    cw_ready_i = 1'b0;
    send_sym(4'd3, 4'h2);
    send_sym(4'd3, 4'h1);
    @(negedge clk_i);
    seen0 = cw_seen;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(cw_valid_o),  64'd1);
      check("hold_ready", 64'(sym_ready_o), 64'd0);
      check("hold_word", 64'({cw_code_o, cw_len_o, cw_data_o, cw_flush_o}),
                         64'({4'd3, 6'd7, 21'h55, 1'b0}));
      @(negedge clk_i);
    end
    cw_ready_i = 1'b1;
    @(negedge clk_i);
    check("hold_released", 64'(cw_valid_o), 64'd0);
    check("hold_one_hs",   64'(cw_seen - seen0), 64'd1);
    check("hold_hs_len",   64'(last_len), 64'd7);

    // Reserved nibble is ignored but flags an error
    send_sym(4'd4, 4'hF);
    check("nibF_err",   64'(ovf_err_o),   64'd1);
    check("nibF_ready", 64'(sym_ready_o), 64'd1);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    check("rst2_err", 64'(ovf_err_o), 64'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Code 0 overflow after MAX_SYMS unmatched symbols
    for (int i = 1; i <= 6; i++) begin
      send_sym(4'd0, 4'(i));
      if (i == 5) begin
        @(negedge clk_i);
        check("ovf_not_yet", 64'(ovf_err_o), 64'd0);
      end
    end
    @(negedge clk_i);
    check("ovf_set", 64'(ovf_err_o), 64'd1);
    seen0 = cw_seen;
    send_sym(4'd0, 4'h7);
    repeat (2) @(negedge clk_i);
    check("ovf_prefix_cleared", 64'(cw_seen - seen0), 64'd1);
    check("ovf_after_word", 64'({last_code, last_len, last_data, last_flush}),
                            64'({4'd0, 6'd3, 21'h5, 1'b0}));

    // Symbol and flush in the same cycle
    cyc = 0;
    while (!sym_ready_o && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    seen0 = cw_seen;
    sym_valid_i = 1'b1;
    sym_code_i  = 4'd2;
    sym_data_i  = 4'hB;
    flush_i     = 1'b1;
    @(negedge clk_i);
    sym_valid_i = 1'b0;
    flush_i     = 1'b0;
    check("simul_lkp_code", 64'(lkp_code_o), 64'd2);
    check("simul_lkp_cnt",  64'(lkp_cnt_o),  64'd1);
    check("simul_lkp_data", lkp_data_o,      64'hB);
    wait_done(cyc);
    check("simul_count", 64'(cw_seen - seen0), 64'd1);
    check("simul_word", 64'({last_code, last_len, last_data, last_flush}),
                        64'({4'd2, 6'd5, 21'h1B, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
